// File: rtl/hp_seq_ctrl.sv
// hp_seq_ctrl: sample buffer and pass sequencer for the high-pass FIR.
// Stereo samples go into a circular buffer. Once TAPS samples are held, each
// new sample launches one pass that streams the last TAPS samples, oldest
// first, one cycle behind the sequencing strobe to line up with the
// registered coefficient ROM.
module hp_seq_ctrl #(
   parameter int DEPTH = 1024,
   parameter int TAPS  = 1021,
   parameter int AW    = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid,
   input  logic signed [15:0] lft_in,
   input  logic signed [15:0] rght_in,
   output logic               sequencing,
   output logic signed [15:0] lft_smpl,
   output logic signed [15:0] rght_smpl,
   output logic               filt_done,
   output logic               overrun
);

   typedef enum logic [1:0] {IDLE, SEQ, DONE} state_t;

   localparam logic [AW-1:0] TAPS_A = AW'(TAPS);
   localparam logic [AW-1:0] LAST_K = AW'(TAPS - 1);
   localparam logic [AW-1:0] ONE_A  = AW'(1);

   logic [31:0]   mem [DEPTH];
   state_t        state_q;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] fill_q, fill_d;    // saturates at TAPS, which is < DEPTH
   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] cnt_q;             // k within the pass
   logic          pending_q;
   logic          seq_q, done_q, ovr_q;
   logic          req;

   // Next write pointer / fill level; a request is any write that leaves the
   // buffer holding a full window.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      if (valid) begin
         wr_ptr_d = wr_ptr_q + ONE_A;
         if (fill_q != TAPS_A) fill_d = fill_q + ONE_A;
      end
      req = valid && (fill_d == TAPS_A);
   end

   // Sample storage; writes happen in every state.
   always_ff @(posedge clk) begin
      if (valid) mem[wr_ptr_q] <= {lft_in, rght_in};
   end

   // Registered buffer read; zero outside data cycles so the filter
   // accumulators hold still between passes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lft_smpl  <= '0;
         rght_smpl <= '0;
      end else if (state_q == SEQ) begin
         {lft_smpl, rght_smpl} <= mem[rd_ptr_q];
      end else begin
         lft_smpl  <= '0;
         rght_smpl <= '0;
      end
   end

   // Pass sequencer with pending/overrun bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         fill_q    <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         seq_q     <= 1'b0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         done_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req || pending_q) begin
                  state_q   <= SEQ;
                  seq_q     <= 1'b1;
                  pending_q <= 1'b0;
                  // oldest of the newest TAPS samples, including this write
                  rd_ptr_q  <= wr_ptr_d - TAPS_A;
                  cnt_q     <= '0;
               end
            end
            SEQ: begin
               rd_ptr_q <= rd_ptr_q + ONE_A;
               cnt_q    <= cnt_q + ONE_A;
               if (cnt_q == LAST_K) begin
                  state_q <= DONE;
                  seq_q   <= 1'b0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
         // a request while busy is parked; a second one is lost
         if (state_q != IDLE && req) begin
            if (pending_q) ovr_q     <= 1'b1;
            else           pending_q <= 1'b1;
         end
      end
   end

   assign sequencing = seq_q;
   assign filt_done  = done_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_hp_seq_ctrl.sv
// tb_hp_seq_ctrl: directed phases plus random sample traffic, checked every
// cycle against a pass-schedule reference model built on a sample history.
module tb_hp_seq_ctrl;

   localparam int TAPS = 1021;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               valid = 1'b0;
   logic signed [15:0] lft_in = '0, rght_in = '0;
   logic               sequencing, filt_done, overrun;
   logic signed [15:0] lft_smpl, rght_smpl;

   hp_seq_ctrl #(.DEPTH(1024), .TAPS(TAPS), .AW(10)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .lft_in(lft_in), .rght_in(rght_in),
      .sequencing(sequencing), .lft_smpl(lft_smpl), .rght_smpl(rght_smpl),
      .filt_done(filt_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;

   // reference model: every sample since reset, plus the latest pass launch
   logic [31:0] hist[$];
   int  e_cnt = 0;      // edge index
   int  n_wr  = 0;      // samples written since reset
   bit  have_l = 0;     // a pass has been launched since reset
   int  l_edge = 0;     // edge at which the latest pass launched
   int  base  = 0;      // hist index of that pass's oldest sample
   bit  m_pend = 0, m_ovr = 0;
   int  seq_cnt = 0, done_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e_cnt, act, exp);
      end
   endtask

   // one clock: drive at negedge, update model at posedge, check just after
   task automatic step(input bit v, input logic [15:0] l, input logic [15:0] r, input bit rst);
      bit req, idle, e_seq, e_done;
      logic [31:0] e_smpl;
      @(negedge clk);
      valid = v; lft_in = l; rght_in = r; rst_n = ~rst;
      @(posedge clk);
      e_cnt++;
      if (rst) begin
         hist.delete(); n_wr = 0; have_l = 0; m_pend = 0; m_ovr = 0;
      end else begin
         if (v) begin hist.push_back({l, r}); n_wr++; end
         req  = v && (n_wr >= TAPS);
         idle = !have_l || (e_cnt >= l_edge + TAPS + 2);
         if (idle) begin
            if (req || m_pend) begin
               have_l = 1; l_edge = e_cnt; base = n_wr - TAPS; m_pend = 0;
            end
         end else if (req) begin
            if (m_pend) m_ovr = 1; else m_pend = 1;
         end
      end
      e_seq  = have_l && e_cnt >= l_edge && e_cnt <= l_edge + TAPS - 1;
      e_done = have_l && e_cnt == l_edge + TAPS + 1;
      e_smpl = (have_l && e_cnt >= l_edge + 1 && e_cnt <= l_edge + TAPS)
               ? hist[base + e_cnt - l_edge - 1] : 32'h0;
      #1;
      chk("sequencing", {31'd0, sequencing}, {31'd0, e_seq});
      chk("lft_smpl",   {16'd0, lft_smpl},   {16'd0, e_smpl[31:16]});
      chk("rght_smpl",  {16'd0, rght_smpl},  {16'd0, e_smpl[15:0]});
      chk("filt_done",  {31'd0, filt_done},  {31'd0, e_done});
      chk("overrun",    {31'd0, overrun},    {31'd0, m_ovr});
      if (sequencing) seq_cnt++;
      if (filt_done) done_cnt++;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(0, 16'h0, 16'h0, 0);
   endtask

   task automatic one(input logic [15:0] l);
      step(1, l, 16'($urandom), 0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) step(0, 16'h0, 16'h0, 1);

      // fill to one short of a window: nothing may happen
      for (int i = 1; i <= TAPS - 1; i++) one(16'(i));
      chk("no_seq_during_fill", seq_cnt, 0);
      one(16'(TAPS));                       // first pass
      idle_n(1030);
      chk("first_pass_len", seq_cnt, TAPS);
      chk("first_pass_done", done_cnt, 1);

      // pending: second request 300 cycles into a pass
      one(16'(TAPS + 1));
      idle_n(299);
      one(16'(TAPS + 2));
      idle_n(2100);
      chk("pending_passes", done_cnt, 3);
      chk("pending_no_ovr", {31'd0, overrun}, 32'd0);

      // overrun: two extra requests during one pass
      one(16'(TAPS + 3));
      idle_n(100); one(16'(TAPS + 4));
      idle_n(100); one(16'(TAPS + 5));
      idle_n(2200);
      chk("ovr_passes", done_cnt, 5);
      chk("ovr_sticky", {31'd0, overrun}, 32'd1);

      // random traffic, including short bursts
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            for (int j = 0; j < int'($urandom_range(1, 4)); j++)
               step(1, 16'($urandom), 16'($urandom), 0);
         end else step(0, 16'h0, 16'h0, 0);
      end
      idle_n(1100);

      // reset mid-pass, then refill from scratch
      step(0, 16'h0, 16'h0, 1);
      for (int i = 1; i <= TAPS; i++) one(16'(i + 7));
      idle_n(500);
      step(0, 16'h0, 16'h0, 1);
      chk("rst_kills_seq", {31'd0, sequencing}, 32'd0);
      seq_cnt = 0; done_cnt = 0;
      for (int i = 1; i <= TAPS - 1; i++) one(16'(i + 100));
      idle_n(50);
      chk("refill_no_seq", seq_cnt, 0);
      chk("refill_no_done", done_cnt, 0);
      one(16'h7fff);
      idle_n(1030);
      chk("refill_pass", seq_cnt, TAPS);
      chk("refill_done", done_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/hp_seq_ctrl.md
Name: hp_seq_ctrl

Overview:
Sample-buffer and sequencing controller for the high-pass FIR filter block. It stores incoming stereo samples in a circular buffer. Once TAPS samples are held, each new sample launches one filter pass. During a pass it drives the filter's sequencing strobe and streams the most recent TAPS samples, oldest first, aligned to the filter's registered coefficient ROM. It also flags when the filter's accumulated output is valid.

Parameters:
DEPTH, 1024, buffer entries (power of 2, > TAPS)
TAPS, 1021, samples per filter pass (coefficient count)
AW, 10, buffer address width, log2(DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset; synchronous, active-low
valid  in  1  one-cycle strobe: new sample pair on lft_in/rght_in
lft_in  in  16  signed left sample
rght_in  in  16  signed right sample
sequencing  out  1  filter pass active; drives filter sequencing input
lft_smpl  out  16  signed left sample to filter
rght_smpl  out  16  signed right sample to filter
filt_done  out  1  one-cycle pulse: filter outputs valid
overrun  out  1  sticky: a sample request was lost

Behaviour:
- Reset (rst_n low at a clock edge):
  - wr_ptr=0, fill count=0, state=IDLE, pending=0.
  - sequencing=0, lft_smpl=rght_smpl=0, filt_done=0, overrun=0.
  - Buffer contents are don't-care.
  - Reset mid-pass aborts the pass immediately; no filt_done is issued.
- Write path:
  - On valid, write {lft_in,rght_in} to mem[wr_ptr] and increment wr_ptr mod DEPTH.
  - The fill count saturates at TAPS.
  - Writes occur in every state. They never corrupt the active window because DEPTH > TAPS.
- Pass request: a valid that leaves the fill count equal to TAPS requests a pass. This includes the valid that first reaches TAPS.
- States:
  - IDLE:
    - If a request is present, or pending=1: go to SEQ next edge and clear pending.
    - Latch start = wr_ptr_new - TAPS (mod DEPTH), where wr_ptr_new includes that cycle's write. This is the oldest of the last TAPS samples.
  - SEQ:
    - sequencing=1 for exactly TAPS cycles, k=0..TAPS-1.
    - Cycle k issues read address start+k (mod DEPTH, wrapping DEPTH-1 to 0).
    - The buffer read is registered, so sample k appears on lft_smpl/rght_smpl in cycle k+1. This matches the filter's ROM, which outputs coefficient k in cycle k+1 after sequencing rises.
    - After cycle TAPS-1, go to DONE.
  - DONE:
    - One cycle; the last sample (k=TAPS-1) is on the outputs.
    - Next cycle: filt_done=1 for one cycle, then return to IDLE.
- Latency: for a valid sampled at edge t, sequencing is high in cycles t+1..t+TAPS and filt_done is high in cycle t+TAPS+2.
- Sample outputs are forced to 0 in every cycle that is not a data cycle (k+1, k=0..TAPS-1). This stops the filter accumulators from drifting while idle, so filter outputs stay stable from filt_done until the next pass.
- Request arrival outside IDLE (SEQ/DONE):
  - The write still occurs and pending is set.
  - If pending is already 1, the request is dropped and overrun is set. overrun clears only on reset.
  - A pending pass starts from IDLE with start computed from wr_ptr at that moment (newest data).
- Simultaneous valid in the IDLE cycle: handled as a normal request; no pending is set.
- Only one pass is in flight at a time; sequencing never re-rises without at least one low cycle. This guarantees the filter's rising-edge detect clears its accumulator.

Test Plan:
- Fill: reset, 1020 valids with samples 1..1020 -> sequencing stays 0, outputs 0, filt_done never pulses.
- First pass: 1021st valid at edge t -> sequencing high cycles t+1..t+1021; lft_smpl=1,2,...,1021 in cycles t+2..t+1022; 0 before and after; filt_done pulse at t+1023.
- Wrap: 1100 total valids, samples = index -> the last pass streams samples 80..1100 in order across the read-address wrap 1023 to 0; no gap or duplicate.
- Pending: a valid 300 cycles into a pass -> the pass completes unchanged; after filt_done, one IDLE cycle, then a new pass starts with the window advanced by 1 and overrun=0.
- Overrun: two valids during one pass -> exactly one extra pass runs and overrun=1, held until reset.
- Reset mid-pass: rst_n low at k=500 -> next cycle sequencing=0, outputs 0, no filt_done; the next 1021 valids are needed before a pass starts.
